// File: rtl/wasm_pkg.sv
// wasm_pkg: shared types for the WebAssembly call/return sequencer
package wasm_pkg;
  localparam int FRAME_AW = 16;
  typedef enum logic [2:0] {
    IDLE, CALL_PUSH, ZERO, RET_RD, RET_WR, RET_POP, FINISH, TRAP
  } call_state_t;
  typedef enum logic [2:0] {
    TRAP_NONE, TRAP_UNREACHABLE, TRAP_CALL_STACK_EXHAUSTED, TRAP_STACK_OVERFLOW
  } trap_t;
  typedef struct packed {
    logic [31:0]         return_pc;
    logic [FRAME_AW-1:0] locals_base;
  } frame_entry_t;
endpackage

// File: rtl/wasm_call_ctrl.sv
// wasm_call_ctrl: call/return frame sequencer; WASM_CALL_STATS_EN adds max_depth output
module wasm_call_ctrl
  import wasm_pkg::*;
#(
  parameter int ADDR_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              call_req,
  input  logic [31:0]       call_target_pc,
  input  logic [31:0]       call_ret_pc,
  input  logic [CNT_W-1:0]  call_num_params,
  input  logic [CNT_W-1:0]  call_num_locals,
  input  logic              ret_req,
  input  logic [CNT_W-1:0]  ret_num_results,
  input  logic [ADDR_W-1:0] cur_sp,
  input  logic [ADDR_W-1:0] cur_locals_base,
  output logic              cs_push_en,
  output frame_entry_t      cs_push_data,
  output logic              cs_pop_en,
  input  frame_entry_t      cs_pop_data,
  input  logic              cs_full,
  input  logic              cs_empty,
  output logic [ADDR_W-1:0] os_addr,
  output logic              os_we,
  output logic [31:0]       os_wdata,
  input  logic [31:0]       os_rdata,
  output logic              pc_load,
  output logic [31:0]       new_pc,
  output logic [ADDR_W-1:0] new_sp,
  output logic [ADDR_W-1:0] new_locals_base,
  output logic              busy,
  output logic              done,
  output logic              halt,
  output trap_t             trap
`ifdef WASM_CALL_STATS_EN
  , output logic [7:0]      max_depth
`endif
);
  call_state_t state, nxt;
  logic [CNT_W-1:0] i, cnt_q, params_q;
  logic [31:0] tgt_q, ret_pc_q;
  logic [ADDR_W-1:0] sp_q, base_q;
  logic trap_done, last;
  assign last = i == cnt_q - CNT_W'(1);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:      nxt = call_req ? (cs_full ? TRAP : CALL_PUSH) :
                       (ret_req && !cs_empty) ? (ret_num_results == '0 ? RET_POP : RET_RD) : IDLE;
      CALL_PUSH: nxt = cnt_q != '0 ? ZERO : FINISH;
      ZERO:      nxt = last ? FINISH : ZERO;
      RET_RD:    nxt = RET_WR;
      RET_WR:    nxt = last ? RET_POP : RET_RD;
      RET_POP:   nxt = FINISH;
      FINISH:    nxt = IDLE;
      TRAP:      nxt = TRAP;
      default:   nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      i <= '0;
      cnt_q <= '0;
      params_q <= '0;
      tgt_q <= '0;
      ret_pc_q <= '0;
      sp_q <= '0;
      base_q <= '0;
      new_pc <= '0;
      new_sp <= '0;
      new_locals_base <= '0;
      halt <= 1'b0;
      trap_done <= 1'b0;
    end else begin
      state <= nxt;
      halt <= state == IDLE && !call_req && ret_req && cs_empty;
      trap_done <= state == IDLE && call_req && cs_full;
      if (state == IDLE) begin
        i <= '0;
        sp_q <= cur_sp;
        base_q <= cur_locals_base;
        cnt_q <= call_req ? call_num_locals : ret_num_results;
        if (call_req) begin
          tgt_q <= call_target_pc;
          ret_pc_q <= call_ret_pc;
          params_q <= call_num_params;
        end
      end
      if (state == ZERO || state == RET_WR) i <= last ? '0 : i + CNT_W'(1);
      if (state == CALL_PUSH) begin
        new_pc <= tgt_q;
        new_locals_base <= sp_q - ADDR_W'(params_q);
        new_sp <= sp_q + ADDR_W'(cnt_q);
      end
      if (state == RET_POP) begin
        new_pc <= cs_pop_data.return_pc;
        new_locals_base <= ADDR_W'(cs_pop_data.locals_base);
        new_sp <= base_q + ADDR_W'(cnt_q);
      end
    end
  // Return copy reads the callee's top results and writes them at the callee base, ascending
  assign os_addr = state == ZERO   ? sp_q + ADDR_W'(i) :
                   state == RET_RD ? sp_q - ADDR_W'(cnt_q) + ADDR_W'(i) :
                   state == RET_WR ? base_q + ADDR_W'(i) : '0;
  assign os_we = state == ZERO || state == RET_WR;
  assign os_wdata = state == RET_WR ? os_rdata : '0;
  assign cs_push_en = state == CALL_PUSH;
  assign cs_push_data = '{return_pc: ret_pc_q, locals_base: FRAME_AW'(base_q)};
  assign cs_pop_en = state == RET_POP;
  assign pc_load = state == FINISH;
  assign done = state == FINISH || halt || trap_done;
  assign busy = state != IDLE;
  assign trap = state == TRAP ? TRAP_CALL_STACK_EXHAUSTED : TRAP_NONE;
`ifdef WASM_CALL_STATS_EN
  logic [15:0] depth;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      depth <= '0;
      max_depth <= '0;
    end else begin
      depth <= depth + 16'(cs_push_en) - 16'(cs_pop_en);
      if (cs_push_en && max_depth != 8'hff && depth + 16'd1 > 16'(max_depth)) max_depth <= max_depth + 8'd1;
    end
`endif
endmodule
